// File: rtl/router_fifo_pkt.sv
// router_fifo_pkt: packet-aware router output FIFO with header tagging, remaining-length tracking and fill status.
// Optional build macro ROUTER_FIFO_PKT_ERR_EN enables the sticky err_flag (overflow, underflow, truncated packet).
module router_fifo_pkt #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 4,
   parameter int LEN_MSB   = 7,
   parameter int LEN_LSB   = 2,
   parameter int AFULL_LVL = 14
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              soft_reset,
   input  logic              write_enb,
   input  logic              read_enb,
   input  logic              lfd_state,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              out_valid,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic [ADDR_W:0]   fill_level,
   output logic              pkt_done,
   output logic              err_flag
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam int REM_W = (ADDR_W + 3 < 7) ? 7 : ADDR_W + 3;

   logic [DATA_W:0]   mem [DEPTH];
   logic [ADDR_W:0]   wr_ptr, rd_ptr;
   logic [REM_W-1:0]  rem, rem_nxt;
   logic [DATA_W:0]   rd_entry;
   logic              tag_q, wr_ok, rd_ok, rd_tag, clr;

   assign clr         = !resetn || soft_reset;
   assign full        = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) && (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
   assign empty       = wr_ptr == rd_ptr;
   assign fill_level  = wr_ptr - rd_ptr;
   assign almost_full = fill_level >= (ADDR_W+1)'(AFULL_LVL);
   assign wr_ok       = write_enb && !full;
   assign rd_ok       = read_enb && !empty;
   assign rd_entry    = mem[rd_ptr[ADDR_W-1:0]];
   assign rd_tag      = rd_entry[DATA_W];

   // A header read reloads the count (payload plus parity); payload reads count down to zero.
   always_comb begin
      rem_nxt = !rd_ok ? rem
              : rd_tag ? REM_W'(rd_entry[LEN_MSB:LEN_LSB]) + REM_W'(1)
              : (rem != '0) ? rem - REM_W'(1) : rem;
   end

   // Storage: each entry carries the delayed header tag alongside the byte.
   always_ff @(posedge clock) begin
      if (wr_ok && !clr) mem[wr_ptr[ADDR_W-1:0]] <= {tag_q, data_in};
   end

   // Pointer, tag, remaining-count and status pulses; flush clears them all.
   always_ff @(posedge clock) begin
      if (clr) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         rem       <= '0;
         tag_q     <= 1'b0;
         out_valid <= 1'b0;
         pkt_done  <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         rem       <= rem_nxt;
         tag_q     <= lfd_state;
         out_valid <= rd_ok;
         pkt_done  <= rd_ok && !rd_tag && (rem == REM_W'(1));
      end
   end

   // Read data survives a channel flush; only a full reset clears it.
   always_ff @(posedge clock) begin
      if (!resetn) data_out <= '0;
      else if (!soft_reset && rd_ok) data_out <= rd_entry[DATA_W-1:0];
   end

`ifdef ROUTER_FIFO_PKT_ERR_EN
   logic err_q;
   // Sticky error on overflow, underflow or a header arriving before the previous packet finished.
   always_ff @(posedge clock) begin
      if (clr) err_q <= 1'b0;
      else if ((write_enb && full) || (read_enb && empty) || (rd_ok && rd_tag && rem != '0)) err_q <= 1'b1;
   end
   assign err_flag = err_q;
`else
   assign err_flag = 1'b0;
`endif
endmodule

// File: tb/tb_router_fifo_pkt.sv
// tb_router_fifo_pkt: vector table, corner sequences and random traffic against a queue-based reference model.
module tb_router_fifo_pkt;
   logic       clock = 1'b0, resetn, soft_reset, write_enb, read_enb, lfd_state;
   logic [7:0] data_in, data_out;
   logic       out_valid, full, empty, almost_full, pkt_done, err_flag;
   logic [4:0] fill_level;
   int         tests = 0, fails = 0;

   router_fifo_pkt dut (
      .clock(clock), .resetn(resetn), .soft_reset(soft_reset), .write_enb(write_enb),
      .read_enb(read_enb), .lfd_state(lfd_state), .data_in(data_in), .data_out(data_out),
      .out_valid(out_valid), .full(full), .empty(empty), .almost_full(almost_full),
      .fill_level(fill_level), .pkt_done(pkt_done), .err_flag(err_flag)
   );

   always #5 clock = ~clock;

   logic [8:0] q[$];
   int         m_rem = 0;
   logic       m_tag = 0, m_valid = 0, m_done = 0, m_err = 0;
   logic [7:0] m_dout = 0;

   typedef struct {
      logic rn, sr, we, re, lfd;
      logic [7:0] din;
      logic cd;
      logic [7:0] dout;
      logic valid, done;
      int fill;
   } vec_t;
   vec_t tbl[14];

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic model(input logic rn, sr, we, re, lfd, input logic [7:0] din);
      logic [8:0] e;
      logic wr, rd;
      if (!rn || sr) begin
         q.delete();
         m_rem = 0; m_tag = 0; m_valid = 0; m_done = 0; m_err = 0;
         if (!rn) m_dout = 0;
         return;
      end
      wr = we && q.size() < 16;
      rd = re && q.size() > 0;
`ifdef ROUTER_FIFO_PKT_ERR_EN
      if ((we && q.size() == 16) || (re && q.size() == 0)) m_err = 1;
`endif
      m_valid = rd;
      m_done = 0;
      if (rd) begin
         e = q.pop_front();
         m_dout = e[7:0];
         if (e[8]) begin
`ifdef ROUTER_FIFO_PKT_ERR_EN
            if (m_rem > 0) m_err = 1;
`endif
            m_rem = int'(e[7:2]) + 1;
         end else if (m_rem > 0) begin
            m_rem--;
            m_done = (m_rem == 0);
         end
      end
      if (wr) q.push_back({m_tag, din});
      m_tag = lfd;
   endtask

   task automatic step(input logic rn, sr, we, re, lfd, input logic [7:0] din);
      resetn = rn; soft_reset = sr; write_enb = we; read_enb = re; lfd_state = lfd; data_in = din;
      @(posedge clock);
      model(rn, sr, we, re, lfd, din);
      #1;
      chk("data_out", data_out, m_dout);
      chk("out_valid", out_valid, m_valid);
      chk("pkt_done", pkt_done, m_done);
      chk("fill_level", fill_level, q.size());
      chk("full", full, q.size() == 16);
      chk("empty", empty, q.size() == 0);
      chk("almost_full", almost_full, q.size() >= 14);
      chk("err_flag", err_flag, m_err);
   endtask

   task automatic apply_rows(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         step(tbl[i].rn, tbl[i].sr, tbl[i].we, tbl[i].re, tbl[i].lfd, tbl[i].din);
         if (tbl[i].cd) chk($sformatf("vec%0d data_out", i), data_out, tbl[i].dout);
         chk($sformatf("vec%0d out_valid", i), out_valid, tbl[i].valid);
         chk($sformatf("vec%0d pkt_done", i), pkt_done, tbl[i].done);
         chk($sformatf("vec%0d fill_level", i), fill_level, tbl[i].fill);
      end
   endtask

   initial begin
      tbl[0]  = '{0, 0, 0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0};
      tbl[1]  = '{1, 0, 0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0};
      tbl[2]  = '{1, 0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 0, 0};
      tbl[3]  = '{1, 0, 1, 0, 0, 8'h0D, 0, 8'h00, 0, 0, 1};
      tbl[4]  = '{1, 0, 1, 0, 0, 8'h11, 0, 8'h00, 0, 0, 2};
      tbl[5]  = '{1, 0, 1, 0, 0, 8'h22, 0, 8'h00, 0, 0, 3};
      tbl[6]  = '{1, 0, 1, 0, 0, 8'h33, 0, 8'h00, 0, 0, 4};
      tbl[7]  = '{1, 0, 1, 0, 0, 8'hAA, 0, 8'h00, 0, 0, 5};
      tbl[8]  = '{1, 0, 0, 1, 0, 8'h00, 1, 8'h0D, 1, 0, 4};
      tbl[9]  = '{1, 0, 0, 1, 0, 8'h00, 1, 8'h11, 1, 0, 3};
      tbl[10] = '{1, 0, 0, 1, 0, 8'h00, 1, 8'h22, 1, 0, 2};
      tbl[11] = '{1, 0, 0, 1, 0, 8'h00, 1, 8'h33, 1, 0, 1};
      tbl[12] = '{1, 0, 0, 1, 0, 8'h00, 1, 8'hAA, 1, 1, 0};
      tbl[13] = '{1, 0, 0, 0, 0, 8'h00, 1, 8'hAA, 0, 0, 0};
      resetn = 0; soft_reset = 0; write_enb = 0; read_enb = 0; lfd_state = 0; data_in = 0;
      apply_rows(0, 13);
      chk("reset empty", empty, 1);

      for (int i = 0; i < 16; i++) begin
         step(1, 0, 1, 0, 0, 8'(8'h80 + i));
         chk("fill count", fill_level, i + 1);
         chk("fill almost_full", almost_full, (i + 1) >= 14);
      end
      chk("fill full", full, 1);
      step(1, 0, 1, 0, 0, 8'h55);
      chk("overflow fill_level", fill_level, 16);
`ifdef ROUTER_FIFO_PKT_ERR_EN
      chk("overflow err_flag", err_flag, 1);
`else
      chk("overflow err_flag", err_flag, 0);
`endif
      step(1, 0, 1, 1, 0, 8'h77);
      chk("full rw data_out", data_out, 8'h80);
      chk("full rw fill_level", fill_level, 15);
      while (q.size() > 5) step(1, 0, 0, 1, 0, 8'h00);
      step(1, 0, 1, 1, 0, 8'h66);
      chk("rw5 fill_level", fill_level, 5);
      while (q.size() > 0) step(1, 0, 0, 1, 0, 8'h00);

      for (int i = 0; i < 40; i++) step(1, 0, 1, q.size() >= 3, 0, 8'(i + 8'h40));
      while (q.size() > 0) step(1, 0, 0, 1, 0, 8'h00);
      chk("wrap empty", empty, 1);

      step(1, 0, 0, 0, 1, 8'h00);
      step(1, 0, 1, 0, 0, 8'h0D);
      step(1, 0, 1, 0, 0, 8'h11);
      step(1, 0, 1, 0, 0, 8'h22);
      step(1, 0, 1, 0, 0, 8'h33);
      step(1, 0, 1, 0, 0, 8'hAA);
      step(1, 0, 0, 1, 0, 8'h00);
      step(1, 0, 0, 1, 0, 8'h00);
      step(1, 1, 1, 1, 0, 8'h99);
      chk("sr empty", empty, 1);
      chk("sr fill_level", fill_level, 0);
      chk("sr out_valid", out_valid, 0);
      chk("sr err_flag", err_flag, 0);
      chk("sr data_out hold", data_out, 8'h11);
      chk("sr pkt_done", pkt_done, 0);
      step(1, 0, 0, 0, 0, 8'h00);
      chk("sr idle pkt_done", pkt_done, 0);
      apply_rows(2, 13);

      for (int i = 0; i < 600; i++) begin
         int wp;
         wp = ((i / 60) % 2 == 0) ? 3 : 1;
         step($urandom_range(0, 149) != 0, $urandom_range(0, 79) == 0,
              $urandom_range(0, 3) < wp, $urandom_range(0, 3) >= wp - 1 || $urandom_range(0, 1) == 1,
              $urandom_range(0, 5) == 0, 8'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/router_fifo_pkt.md
Name: router_fifo_pkt

Overview:
Parametrised, packet-aware successor of the router output FIFO. It buffers DATA_W-bit router bytes in a 2^ADDR_W-deep circular memory. Each entry is tagged with a header bit taken from the delayed lfd_state. On the read side it tracks the remaining packet length and reports fill level, almost-full, output-valid and end-of-packet. It sits between the router synchroniser/FSM (write side) and each destination read port, one instance per channel.

Parameters:
- DATA_W, 8, byte width of data_in/data_out.
- ADDR_W, 4, address bits; DEPTH = 2^ADDR_W entries (16).
- LEN_MSB, 7, MSB of the payload-length field inside a header byte.
- LEN_LSB, 2, LSB of the payload-length field inside a header byte.
- AFULL_LVL, 14, fill level at or above which almost_full asserts; must be 1..DEPTH.

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  synchronous, active-low reset
- soft_reset  in  1  synchronous channel flush, active-high
- write_enb  in  1  write request
- read_enb  in  1  read request
- lfd_state  in  1  header-load indication, one cycle ahead of the header byte
- data_in  in  DATA_W  write data
- data_out  out  DATA_W  registered read data
- out_valid  out  1  data_out updated by a read on the last edge
- full  out  1  DEPTH entries stored
- empty  out  1  zero entries stored
- almost_full  out  1  fill_level >= AFULL_LVL
- fill_level  out  ADDR_W+1  entries stored, 0..DEPTH
- pkt_done  out  1  one-cycle pulse when the last byte (parity) of a packet is read
- err_flag  out  1  sticky error flag; see Optional Feature

Behaviour:
- Reset (resetn=0 at a rising edge): pointers, fill_level, remaining-count and tag register clear to 0. data_out=0, out_valid=0, pkt_done=0, err_flag=0, empty=1, full=0, almost_full=0. Memory contents are not cleared.
- Priority order: resetn, then soft_reset, then normal operation.
- soft_reset: identical to reset for all state except data_out, which holds its value. Memory is not cleared.
- Pointers are ADDR_W+1 bits wide. The MSB is the wrap bit.
  - full = MSBs differ and low bits are equal.
  - empty = pointers equal.
  - full, empty and almost_full are combinational from registered state.
- Tag: tag_q <= lfd_state every edge. A write stores {tag_q, data_in}, so the header byte must arrive one cycle after lfd_state.
- Write: accepted when write_enb=1 and full=0. It stores the entry at wr_ptr and increments wr_ptr modulo 2*DEPTH. Writes while full are dropped with no state change.
- Read: accepted when read_enb=1 and empty=0.
  - data_out <= mem[rd_ptr] data bits, out_valid <= 1, rd_ptr increments.
  - Latency is one clock.
  - Reads while empty are ignored: out_valid <= 0 and data_out holds.
  - On any cycle without an accepted read, out_valid <= 0.
- Full and empty are evaluated from the state before the edge:
  - Read and write in the same cycle while full: the read is accepted, the write is dropped.
  - Read and write in the same cycle while empty: the write is accepted, the read is ignored.
  - Otherwise both are accepted and fill_level is unchanged.
- fill_level: +1 on write only, -1 on read only, unchanged on both or neither.
- Remaining count (rem, ADDR_W+3 bits wide, minimum 7):
  - An accepted read of an entry with tag=1 loads rem <= data[LEN_MSB:LEN_LSB] + 1 (payload plus parity).
  - An accepted read of an entry with tag=0 and rem>0 decrements rem.
  - pkt_done pulses the cycle after the read that takes rem from 1 to 0.
  - A header with length field 0 loads rem=1.
  - A tag=0 read while rem=0 leaves rem=0 and gives no pulse.
  - rem reloads only on header reads, never on header writes.
- A header read while rem>0 (truncated packet) overwrites rem with no pkt_done pulse.

Optional Feature:
- Macro: ROUTER_FIFO_PKT_ERR_EN.
- Defined: err_flag sets sticky on any of the following, and clears only on reset or soft_reset:
  - write_enb while full (overflow);
  - read_enb while empty (underflow);
  - header read while rem>0.
- Not defined: err_flag is driven constant 0 and no error logic is synthesised.
- The port exists in both builds.

Test Plan:
- Reset then idle: empty=1, fill_level=0, data_out=0x00, out_valid=0, pkt_done=0.
- Packet through: lfd_state=1 at cycle N, then write 0x0D, 0x11, 0x22, 0x33, 0xAA on cycles N+1..N+5, then read 5 times. Required: data_out 0x0D, 0x11, 0x22, 0x33, 0xAA each one cycle after its read; out_valid high for those 5 cycles; pkt_done pulses exactly once, on the cycle after the 0xAA read.
- Fill: 16 writes with no reads. fill_level reaches 16, almost_full asserts after write 14, full=1. A 17th write of 0x55 is dropped: fill_level stays 16, and with ROUTER_FIFO_PKT_ERR_EN defined, err_flag=1.
- Simultaneous: from full, read+write of 0x77 in the same cycle: one entry read, 0x77 not stored, fill_level=15. From fill_level=5, read+write: fill_level stays 5.
- Wrap: 40 writes interleaved with reads, never exceeding 16 entries. Data comes out in order across the pointer wrap, with no false full/empty.
- soft_reset mid-packet after 2 of 5 bytes read: empty=1, fill_level=0, out_valid=0, err_flag=0, data_out holds its last value, no pkt_done. The next packet behaves as in the packet-through scenario.
